// File: rtl/temp_sampler.sv
`default_nettype none
// ============================================================================
// Module      : temp_sampler
// Description : XADC DRP read sequencer and 2**AVG_LOG2-sample averager for
//               the on-board temperature channel. Publishes a 12-bit averaged
//               code plus a sticky ready level.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_sampler #(
    parameter logic [6:0] CHANNEL_ADDR = 7'h13,
    parameter int         AVG_LOG2     = 2,
    parameter int         TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [11:0] digitalTemp,
    output logic        ready,
    output logic        timeout_err
);

    localparam int                 c_ACC_W      = 12 + AVG_LOG2;
    localparam int                 c_CNT_W      = AVG_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL   = c_CNT_W'(1 << AVG_LOG2);
    localparam logic [7:0]         c_TIMER_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_PUBLISH = 2'd2;

    logic [1:0]         r_state,       w_state_nxt;
    logic               r_den,         w_den_nxt;
    logic               r_timeout_err, w_timeout_err_nxt;
    logic [c_ACC_W-1:0] r_acc,         w_acc_nxt;
    logic [c_CNT_W-1:0] r_cnt,         w_cnt_nxt;
    logic [7:0]         r_timer,       w_timer_nxt;
    logic [11:0]        r_temp,        w_temp_nxt;
    logic               r_ready,       w_ready_nxt;

    logic [c_ACC_W-1:0] w_sample;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_unused;

    // The conversion result is left-justified; the low nibble carries no data.
    assign w_sample  = c_ACC_W'(do_in[15:4]);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_unused  = ^do_in[3:0];

    // Next-state and datapath decode; eoc outside IDLE is simply not looked at.
    always_comb begin
        w_state_nxt       = r_state;
        w_den_nxt         = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_acc_nxt         = r_acc;
        w_cnt_nxt         = r_cnt;
        w_timer_nxt       = r_timer;
        w_temp_nxt        = r_temp;
        w_ready_nxt       = r_ready;

        case (r_state)
            c_ST_IDLE: begin
                if (eoc) begin
                    w_den_nxt   = 1'b1;
                    w_timer_nxt = 8'd0;
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_timer_nxt = r_timer + 8'd1;
                if (drdy) begin
                    w_acc_nxt = r_acc + w_sample;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_CNT_FULL) begin
                        w_state_nxt = c_ST_PUBLISH;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (r_timer == c_TIMER_LAST) begin
                    // Lost read: drop the slot, keep the partial average intact.
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = c_ST_IDLE;
                end
            end
            c_ST_PUBLISH: begin
                // Divide by a power of two with plain truncation.
                w_temp_nxt  = r_acc[AVG_LOG2 +: 12];
                w_ready_nxt = 1'b1;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= c_ST_IDLE;
            r_den         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_timer       <= 8'd0;
            r_temp        <= 12'd0;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_den         <= w_den_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timer       <= w_timer_nxt;
            r_temp        <= w_temp_nxt;
            r_ready       <= w_ready_nxt;
        end
    end

    assign den         = r_den;
    assign dwe         = 1'b0;
    assign daddr       = CHANNEL_ADDR;
    assign digitalTemp = r_temp;
    assign ready       = r_ready;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_temp_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_sampler
// Description : Directed plus randomized bench for temp_sampler. Expected
//               averages come from a queue of accepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_sampler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = 16'd0;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [11:0] digitalTemp;
    logic        ready;
    logic        timeout_err;

    int n_cmp     = 0;
    int n_err     = 0;
    int den_count = 0;

    int unsigned samples[$];
    int unsigned exp_temp  = 0;
    logic        exp_ready = 1'b0;

    always #5 CLK = ~CLK;

    temp_sampler #(
        .CHANNEL_ADDR (7'h13),
        .AVG_LOG2     (2),
        .TIMEOUT      (255)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .eoc         (eoc),
        .drdy        (drdy),
        .do_in       (do_in),
        .den         (den),
        .dwe         (dwe),
        .daddr       (daddr),
        .digitalTemp (digitalTemp),
        .ready       (ready),
        .timeout_err (timeout_err)
    );

    // One clock; outputs are observed on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        if (den === 1'b1) den_count++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: average every group of four accepted samples.
    function automatic bit model_accept(input int unsigned v);
        int unsigned sum;
        samples.push_back(v);
        if (samples.size() == 4) begin
            sum = 0;
            foreach (samples[i]) sum += samples[i];
            exp_temp  = sum / 4;
            exp_ready = 1'b1;
            samples.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_read(input int unsigned v, input int delay,
                           input bit eoc_mid, input bit eoc_same);
        int          d0;
        int unsigned old_temp;
        logic        old_ready;
        bit          bad;
        bit          full;
        d0        = den_count;
        old_temp  = exp_temp;
        old_ready = exp_ready;
        bad       = 1'b0;
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        check("den_assert", den, 1);
        check("daddr", daddr, 32'h13);
        check("dwe", dwe, 0);
        for (int i = 0; i < delay; i++) begin
            if (eoc_mid && i == 0) eoc = 1'b1;
            step();
            eoc = 1'b0;
            if (den !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
        end
        check("wait_quiet", bad, 0);
        drdy  = 1'b1;
        do_in = {v[11:0], 4'($urandom)};
        if (eoc_same) eoc = 1'b1;
        step();
        drdy  = 1'b0;
        eoc   = 1'b0;
        do_in = 16'($urandom);
        full  = model_accept(v);
        check("den_low_after", den, 0);
        if (full) begin
            check("temp_hold_publish", digitalTemp, old_temp);
            check("ready_hold_publish", ready, old_ready);
        end
        step();
        check("temp", digitalTemp, exp_temp);
        check("ready", ready, exp_ready);
        step();
        check("den_count", den_count - d0, 1);
        check("no_timeout", timeout_err, 0);
    endtask

    task automatic do_timeout();
        bit bad;
        bad = 1'b0;
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        check("to_den", den, 1);
        for (int i = 1; i < 255; i++) begin
            step();
            if (timeout_err !== 1'b0) bad = 1'b1;
        end
        check("to_early", bad, 0);
        step();
        check("to_pulse", timeout_err, 1);
        step();
        check("to_width", timeout_err, 0);
        check("to_temp", digitalTemp, exp_temp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state
        RST = 1'b1;
        repeat (3) step();
        check("rst_den", den, 0);
        check("rst_ready", ready, 0);
        check("rst_temp", digitalTemp, 0);
        check("rst_timeout", timeout_err, 0);
        RST = 1'b0;
        step();

        // 6: reset between den and drdy, late drdy ignored
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        check("mid_den", den, 1);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        samples.delete();
        check("mid_rst_den", den, 0);
        step();
        drdy  = 1'b1;
        do_in = {12'd3000, 4'd0};
        step();
        drdy = 1'b0;
        step();
        step();
        check("mid_ready", ready, 0);
        check("mid_temp", digitalTemp, 0);

        // 2: plain average; ready rises after the first publish
        do_read(1000, 0, 1'b0, 1'b0);
        do_read(1100, 1, 1'b0, 1'b0);
        do_read(1200, 2, 1'b0, 1'b0);
        do_read(1300, 3, 1'b0, 1'b0);
        check("avg_1150", digitalTemp, 1150);

        // 3: full-scale and truncation
        repeat (4) do_read(4095, 1, 1'b0, 1'b0);
        check("avg_fff", digitalTemp, 4095);
        do_read(1, 0, 1'b0, 1'b0);
        do_read(1, 0, 1'b0, 1'b0);
        do_read(1, 0, 1'b0, 1'b0);
        do_read(2, 0, 1'b0, 1'b0);
        check("avg_trunc", digitalTemp, 1);

        // 4: timeout discards the slot
        do_timeout();
        repeat (4) do_read(2000, 2, 1'b0, 1'b0);
        check("avg_after_to", digitalTemp, 2000);

        // 5: collisions
        do_read(10, 3, 1'b1, 1'b0);
        do_read(20, 0, 1'b0, 1'b1);
        do_read(30, 2, 1'b1, 1'b1);
        do_read(41, 1, 1'b0, 1'b1);
        check("avg_collide", digitalTemp, 25);

        // Randomized reads, whole groups
        for (int n = 0; n < 16; n++) begin
            int unsigned v;
            int          d;
            v = $urandom_range(0, 4095);
            d = $urandom_range(0, 6);
            do_read(v, d, (d > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
